// File: rtl/apb_gpio_pkg.sv
// -----------------------------------------------------------------------------
// apb_gpio_pkg
// Shared definitions for the APB GPIO controller: register byte offsets,
// the APB slave state type and the widest supported GPIO bank.
// No ports; imported by apb_gpio_ctrl.
// -----------------------------------------------------------------------------
package apb_gpio_pkg;

   // Widest GPIO bank the register file can expose (one 32-bit register)
   localparam int MAX_GPIO_W = 32;

   // Register byte offsets within the 32-byte window
   localparam logic [4:0] ADDR_DATA_OUT   = 5'h00;
   localparam logic [4:0] ADDR_DIR        = 5'h04;
   localparam logic [4:0] ADDR_DATA_IN    = 5'h08;
   localparam logic [4:0] ADDR_IRQ_EN     = 5'h0C;
   localparam logic [4:0] ADDR_IRQ_TYPE   = 5'h10;
   localparam logic [4:0] ADDR_IRQ_POL    = 5'h14;
   localparam logic [4:0] ADDR_IRQ_STATUS = 5'h18;

   // APB slave transfer state
   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// -----------------------------------------------------------------------------
// gpio_sync_edge
// Brings asynchronous pin inputs into the clock domain through a 2-flop
// synchroniser, then keeps a previous-value copy for edge detection.
// Ports:
//   clk     : core clock, rising edge
//   rst     : asynchronous active-high reset
//   async_i : raw pin inputs [GPIO_W]
//   sync_o  : synchronised pin values [GPIO_W]
//   rise_o  : sync high now, low last cycle [GPIO_W]
//   fall_o  : sync low now, high last cycle [GPIO_W]
// -----------------------------------------------------------------------------
module gpio_sync_edge #(
   parameter int GPIO_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [GPIO_W-1:0] async_i,
   output logic [GPIO_W-1:0] sync_o,
   output logic [GPIO_W-1:0] rise_o,
   output logic [GPIO_W-1:0] fall_o
);

   logic [GPIO_W-1:0] meta_q, meta_d;
   logic [GPIO_W-1:0] sync_q, sync_d;
   logic [GPIO_W-1:0] prev_q, prev_d;

   // Each stage simply shifts the previous one along by a cycle
   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Synchroniser and history flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/apb_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// apb_gpio_ctrl
// APB3 slave GPIO controller: register file, pin output/enable drive,
// synchronised pin inputs, edge/level interrupt status and one IRQ line.
// Ports:
//   PCLK, PRESET         : clock, asynchronous active-high reset
//   PSEL, PENABLE, PWRITE: APB control
//   PADDR, PWDATA        : APB byte address / write data [32]
//   PRDATA, PREADY       : APB read data (registered) / transfer complete
//   IRQ                  : registered interrupt
//   gpio_i               : asynchronous pin inputs [GPIO_W]
//   gpio_o, gpio_oe      : pin output values / output enables [GPIO_W]
// -----------------------------------------------------------------------------
module apb_gpio_ctrl #(
   parameter int GPIO_W      = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              IRQ,
   input  logic [GPIO_W-1:0] gpio_i,
   output logic [GPIO_W-1:0] gpio_o,
   output logic [GPIO_W-1:0] gpio_oe
);

   import apb_gpio_pkg::*;

   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

   apb_state_e        state_q, state_d;
   logic [2:0]        wait_cnt_q, wait_cnt_d;
   logic [31:0]       prdata_q, prdata_d;
   logic [GPIO_W-1:0] data_out_q, data_out_d;
   logic [GPIO_W-1:0] dir_q, dir_d;
   logic [GPIO_W-1:0] irq_en_q, irq_en_d;
   logic [GPIO_W-1:0] irq_type_q, irq_type_d;
   logic [GPIO_W-1:0] irq_pol_q, irq_pol_d;
   logic [GPIO_W-1:0] irq_status_q, irq_status_d;
   logic              irq_q, irq_d;

   logic [GPIO_W-1:0] gpio_sync, gpio_rise, gpio_fall;
   logic [GPIO_W-1:0] edge_evt, level_hit, w1c_mask;
   logic [MAX_GPIO_W-1:0] rd_data;
   logic [4:0]        reg_off;
   logic              addr_ok, xfer_ok, pready, wr_commit;

   // Byte-lane bits of the address carry no meaning for word registers
   logic unused_bits;
   assign unused_bits = ^PADDR[1:0];

   gpio_sync_edge #(
      .GPIO_W (GPIO_W)
   ) u_sync_edge (
      .clk     (PCLK),
      .rst     (PRESET),
      .async_i (gpio_i),
      .sync_o  (gpio_sync),
      .rise_o  (gpio_rise),
      .fall_o  (gpio_fall)
   );

   // Address decode and the single qualifier that lets a write land:
   // completing ACCESS cycle, bus still in access phase, in-window address
   always_comb begin
      addr_ok   = (PADDR[31:5] == 27'd0);
      reg_off   = {PADDR[4:2], 2'b00};
      xfer_ok   = PSEL & PENABLE;
      pready    = (state_q == ACCESS) && (wait_cnt_q == 3'd0);
      wr_commit = pready & xfer_ok & PWRITE & addr_ok;
   end

   // Read mux; out-of-window and reserved offsets read as zero
   always_comb begin
      rd_data = '0;
      if (addr_ok) begin
         case (reg_off)
            ADDR_DATA_OUT:   rd_data = 32'(data_out_q);
            ADDR_DIR:        rd_data = 32'(dir_q);
            ADDR_DATA_IN:    rd_data = 32'(gpio_sync);
            ADDR_IRQ_EN:     rd_data = 32'(irq_en_q);
            ADDR_IRQ_TYPE:   rd_data = 32'(irq_type_q);
            ADDR_IRQ_POL:    rd_data = 32'(irq_pol_q);
            ADDR_IRQ_STATUS: rd_data = 32'(irq_status_q);
            default:         rd_data = '0;
         endcase
      end
   end

   // APB slave FSM. PRDATA is captured as SETUP ends, held while the
   // access is still pending, and drops to zero whenever the FSM leaves
   // ACCESS (completion or abort).
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      prdata_d   = '0;
      case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) state_d = SETUP;
         end
         SETUP: begin
            state_d    = ACCESS;
            wait_cnt_d = WAIT_LOAD;
            prdata_d   = PWRITE ? 32'd0 : rd_data;
         end
         ACCESS: begin
            if (!xfer_ok || pready) begin
               state_d = IDLE;
            end else begin
               prdata_d = prdata_q;
               if (wait_cnt_q != 3'd0) wait_cnt_d = wait_cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Register file writes; DATA_IN is read-only and IRQ_STATUS is W1C
   always_comb begin
      data_out_d = data_out_q;
      dir_d      = dir_q;
      irq_en_d   = irq_en_q;
      irq_type_d = irq_type_q;
      irq_pol_d  = irq_pol_q;
      w1c_mask   = '0;
      if (wr_commit) begin
         case (reg_off)
            ADDR_DATA_OUT:   data_out_d = PWDATA[GPIO_W-1:0];
            ADDR_DIR:        dir_d      = PWDATA[GPIO_W-1:0];
            ADDR_IRQ_EN:     irq_en_d   = PWDATA[GPIO_W-1:0];
            ADDR_IRQ_TYPE:   irq_type_d = PWDATA[GPIO_W-1:0];
            ADDR_IRQ_POL:    irq_pol_d  = PWDATA[GPIO_W-1:0];
            ADDR_IRQ_STATUS: w1c_mask   = PWDATA[GPIO_W-1:0];
            default:         w1c_mask   = '0;
         endcase
      end
   end

   // Interrupt status. Edge bits are sticky and OR the new event in after
   // the W1C clear so a coincident event survives. Level bits simply track
   // the pin against the polarity every cycle, so a W1C cannot hold them low.
   always_comb begin
      edge_evt     = (gpio_rise & irq_pol_q) | (gpio_fall & ~irq_pol_q);
      level_hit    = ~(gpio_sync ^ irq_pol_q);
      irq_status_d = (irq_type_q & ((irq_status_q & ~w1c_mask) | edge_evt))
                   | (~irq_type_q & level_hit);
      irq_d        = |(irq_status_q & irq_en_q);
   end

   // State, register file and interrupt flops
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= IDLE;
         wait_cnt_q   <= '0;
         prdata_q     <= '0;
         data_out_q   <= '0;
         dir_q        <= '0;
         irq_en_q     <= '0;
         irq_type_q   <= '0;
         irq_pol_q    <= '0;
         irq_status_q <= '0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         prdata_q     <= prdata_d;
         data_out_q   <= data_out_d;
         dir_q        <= dir_d;
         irq_en_q     <= irq_en_d;
         irq_type_q   <= irq_type_d;
         irq_pol_q    <= irq_pol_d;
         irq_status_q <= irq_status_d;
         irq_q        <= irq_d;
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready;
   assign IRQ     = irq_q;
   assign gpio_o  = data_out_q;
   assign gpio_oe = dir_q;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_gpio_ctrl
// Directed self-checking bench for apb_gpio_ctrl with two wait states.
// -----------------------------------------------------------------------------
module tb_apb_gpio_ctrl;

   localparam int GPIO_W      = 32;
   localparam int WAIT_CYCLES = 2;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        IRQ;
   logic [31:0] gpio_i;
   logic [31:0] gpio_o;
   logic [31:0] gpio_oe;

   int          testsRun    = 0;
   int          testsFailed = 0;
   logic [31:0] rdData;
   int          readyCycle;

   apb_gpio_ctrl #(
      .GPIO_W      (GPIO_W),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .IRQ     (IRQ),
      .gpio_i  (gpio_i),
      .gpio_o  (gpio_o),
      .gpio_oe (gpio_oe)
   );

   // 100 MHz clock
   always #5 PCLK = ~PCLK;

   // Safety net so a stuck DUT can never hang the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its expected value and tally it
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One complete APB transfer: one setup cycle, then PENABLE held until
   // PREADY (bounded). Returns the read data seen with PREADY and the number
   // of ACCESS-state cycles up to and including the PREADY cycle. Returns
   // one tick after the completing edge with the bus idle.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic [31:0] rdataOut, output int cycles);
      int n;
      @(posedge PCLK); #1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = wr;
      PADDR   = addr;
      PWDATA  = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      n = 0;
      while (PREADY !== 1'b1 && n < 20) begin
         @(posedge PCLK); #1;
         n++;
      end
      checkOutput("pready_seen", 32'(PREADY), 32'd1);
      rdataOut = PRDATA;
      cycles   = n;
      @(posedge PCLK); #1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
   endtask

   task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] dummy;
      int          cyc;
      applyStimulus(1'b1, addr, data, dummy, cyc);
   endtask

   task automatic readReg(input logic [31:0] addr, input logic [31:0] expected,
                          input string tag);
      logic [31:0] value;
      int          cyc;
      applyStimulus(1'b0, addr, 32'd0, value, cyc);
      checkOutput(tag, value, expected);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   // Directed scenario sequence
   initial begin
      PRESET  = 1'b1;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      PADDR   = '0;
      PWDATA  = '0;
      // Pins high so level-low defaults leave every status bit clear
      gpio_i  = 32'hFFFF_FFFF;
      repeat (3) @(posedge PCLK);
      #1;

      // Reset state
      checkOutput("rst_pready",  32'(PREADY), 32'd0);
      checkOutput("rst_irq",     32'(IRQ),    32'd0);
      checkOutput("rst_prdata",  PRDATA,      32'd0);
      checkOutput("rst_gpio_o",  gpio_o,      32'd0);
      checkOutput("rst_gpio_oe", gpio_oe,     32'd0);
      PRESET = 1'b0;
      waitCycles(5);
      checkOutput("idle_pready", 32'(PREADY), 32'd0);

      // Every offset reads zero except DATA_IN, which shows the pins
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 32'(i * 4), 32'd0, rdData, readyCycle);
         checkOutput($sformatf("reset_read_%0d", i * 4), rdData,
                     (i == 2) ? 32'hFFFF_FFFF : 32'd0);
      end
      checkOutput("irq_after_reset", 32'(IRQ), 32'd0);

      // DATA_OUT write with two wait states: PREADY on 3rd ACCESS cycle
      applyStimulus(1'b1, 32'h00, 32'hA5A5_0F0F, rdData, readyCycle);
      checkOutput("wr_ready_cycle", 32'(readyCycle), 32'd3);
      checkOutput("gpio_o_written", gpio_o, 32'hA5A5_0F0F);
      checkOutput("prdata_idle",    PRDATA, 32'd0);
      applyStimulus(1'b0, 32'h00, 32'd0, rdData, readyCycle);
      checkOutput("rd_ready_cycle", 32'(readyCycle), 32'd3);
      checkOutput("rd_data_out",    rdData, 32'hA5A5_0F0F);
      writeReg(32'h04, 32'hFFFF_0000);
      checkOutput("gpio_oe_written", gpio_oe, 32'hFFFF_0000);
      readReg(32'h04, 32'hFFFF_0000, "rd_dir");

      // Rising-edge interrupt on bit 0
      writeReg(32'h10, 32'h1);
      writeReg(32'h14, 32'h1);
      writeReg(32'h0C, 32'h1);
      gpio_i[0] = 1'b0;
      waitCycles(5);
      checkOutput("irq_no_fall", 32'(IRQ), 32'd0);
      readReg(32'h18, 32'h0, "status_no_fall");
      gpio_i[0] = 1'b1;
      waitCycles(3);
      checkOutput("irq_not_early", 32'(IRQ), 32'd0);
      waitCycles(1);
      checkOutput("irq_edge_4cyc", 32'(IRQ), 32'd1);
      readReg(32'h18, 32'h1, "status_edge");
      readReg(32'h08, 32'hFFFF_FFFF, "data_in_pins");
      writeReg(32'h18, 32'h1);
      waitCycles(1);
      checkOutput("irq_after_w1c", 32'(IRQ), 32'd0);
      readReg(32'h18, 32'h0, "status_after_w1c");

      // Level-low interrupt on bit 3 (TYPE bit3 = 0, POL bit3 = 0)
      writeReg(32'h0C, 32'h9);
      gpio_i[3] = 1'b0;
      waitCycles(5);
      checkOutput("irq_level", 32'(IRQ), 32'd1);
      readReg(32'h18, 32'h8, "status_level");
      writeReg(32'h18, 32'h8);
      waitCycles(2);
      checkOutput("irq_level_w1c", 32'(IRQ), 32'd1);
      readReg(32'h18, 32'h8, "status_level_w1c");
      gpio_i[3] = 1'b1;
      waitCycles(4);
      checkOutput("irq_level_gone", 32'(IRQ), 32'd0);

      // Edge event coinciding with a W1C commit on bit 0: set wins
      gpio_i[0] = 1'b0;
      waitCycles(5);
      gpio_i[0] = 1'b1;
      waitCycles(5);
      checkOutput("irq_edge_again", 32'(IRQ), 32'd1);
      gpio_i[0] = 1'b0;
      waitCycles(5);
      fork
         applyStimulus(1'b1, 32'h18, 32'h1, rdData, readyCycle);
         begin
            // Lands the synchronised rising edge on the commit edge
            repeat (3) @(posedge PCLK);
            #1;
            gpio_i[0] = 1'b1;
         end
      join
      readReg(32'h18, 32'h1, "status_set_wins");
      checkOutput("irq_set_wins", 32'(IRQ), 32'd1);

      // Out-of-window address: write ignored, PREADY normal, reads zero
      applyStimulus(1'b1, 32'h40, 32'hFFFF_FFFF, rdData, readyCycle);
      checkOutput("oow_ready_cycle", 32'(readyCycle), 32'd3);
      checkOutput("oow_gpio_o", gpio_o, 32'hA5A5_0F0F);
      readReg(32'h40, 32'h0, "oow_read");
      readReg(32'h00, 32'hA5A5_0F0F, "oow_no_alias");

      // Reset in the middle of an ACCESS wait state
      @(posedge PCLK); #1;
      PSEL    = 1'b1;
      PENABLE = 1'b0;
      PWRITE  = 1'b1;
      PADDR   = 32'h00;
      PWDATA  = 32'h1234_5678;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      checkOutput("mid_wait_pready", 32'(PREADY), 32'd0);
      PRESET = 1'b1;
      #1;
      checkOutput("midrst_pready", 32'(PREADY), 32'd0);
      checkOutput("midrst_irq",    32'(IRQ),    32'd0);
      checkOutput("midrst_gpio_o", gpio_o,      32'd0);
      checkOutput("midrst_gpio_oe", gpio_oe,    32'd0);
      @(posedge PCLK); #1;
      PRESET  = 1'b0;
      PSEL    = 1'b0;
      PENABLE = 1'b0;
      PWRITE  = 1'b0;
      waitCycles(5);
      readReg(32'h00, 32'h0, "midrst_data_out");
      readReg(32'h0C, 32'h0, "midrst_irq_en");
      applyStimulus(1'b1, 32'h00, 32'h0000_00C3, rdData, readyCycle);
      checkOutput("post_rst_ready", 32'(readyCycle), 32'd3);
      checkOutput("post_rst_gpio_o", gpio_o, 32'h0000_00C3);
      readReg(32'h00, 32'h0000_00C3, "post_rst_read");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
